i2s_sample_transmitter: RTL

- Consumer end of the discrete-sound sample stream.
- Accepts signed 16-bit mono samples strobed by audio_clk_en from any sound circuit (walk, jump, mixer output).
- Serialises each sample onto a standard Philips I2S link, with the same word on left and right, for an external DAC/HDMI audio path.
- Decouples the producer's sample strobe from the I2S frame timing using a one-sample holding register, with underrun/overrun accounting.

---
 rtl/i2s_sample_transmitter.sv | 113 +++++++++++
 1 files changed

// File: rtl/i2s_sample_transmitter.sv
// Serialises 16-bit mono samples onto a Philips I2S link (same word on both channels).
// A one-sample holding register decouples the producer strobe from frame timing.
module i2s_sample_transmitter #(
   parameter int unsigned CLOCK_RATE  = 24576000,
   parameter int unsigned SAMPLE_RATE = 48000,
   parameter int unsigned BCLK_DIV    = CLOCK_RATE / (SAMPLE_RATE * 64)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               audio_clk_en,
   input  logic signed [15:0] in,
   output logic               i2s_bclk,
   output logic               i2s_lrck,
   output logic               i2s_data,
   output logic [15:0]        underrun_count,
   output logic [15:0]        overrun_count
);

   localparam int unsigned DivW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
   localparam logic [DivW-1:0] DivHalf = DivW'(BCLK_DIV / 2);

   if ((BCLK_DIV % 2 != 0) || (BCLK_DIV < 2) ||
       (64'(CLOCK_RATE) != 64'(BCLK_DIV) * 64'(SAMPLE_RATE) * 64'd64)) begin : g_bad_config
      $error("i2s_sample_transmitter: BCLK_DIV must be even, >= 2 and match CLOCK_RATE");
   end

   logic [DivW-1:0] div_q, div_d;
   logic [5:0]      bit_q, bit_d;
   logic [15:0]     holding_q, holding_d;
   logic [15:0]     frame_q, frame_d;
   logic            pending_q, pending_d;
   logic            bclk_q, bclk_d;
   logic            lrck_q, lrck_d;
   logic            data_q, data_d;
   logic [15:0]     underrun_q, underrun_d;
   logic [15:0]     overrun_q, overrun_d;

   logic            bit_edge;
   logic            frame_load;
   logic [4:0]      slot;
   logic [4:0]      bit_idx;

   always_comb begin
      holding_d  = holding_q;
      frame_d    = frame_q;
      pending_d  = pending_q;
      underrun_d = underrun_q;
      overrun_d  = overrun_q;

      bit_edge   = (div_q == DivLast);
      frame_load = bit_edge && (bit_q == 6'd63);
      div_d      = bit_edge ? '0 : div_q + 1'b1;
      bit_d      = bit_edge ? bit_q + 6'd1 : bit_q;

      if (frame_load) begin
         // A strobe landing on the load cycle bypasses straight into the outgoing frame.
         if (audio_clk_en) begin
            frame_d   = in;
            holding_d = in;
         end else begin
            frame_d = holding_q;
            if (!pending_q && (underrun_q != 16'hFFFF)) underrun_d = underrun_q + 16'd1;
         end
         pending_d = 1'b0;
      end else if (audio_clk_en) begin
         holding_d = in;
         pending_d = 1'b1;
         if (pending_q && (overrun_q != 16'hFFFF)) overrun_d = overrun_q + 16'd1;
      end

      // bit_d and frame_d only move on the BCLK falling edge, so lrck/data do too.
      bclk_d  = (div_d >= DivHalf);
      lrck_d  = bit_d[5];
      slot    = bit_d[4:0];
      bit_idx = 5'd16 - slot;
      data_d  = 1'b0;
      if ((slot >= 5'd1) && (slot <= 5'd16)) data_d = frame_d[bit_idx[3:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= '0;
         bit_q      <= '0;
         holding_q  <= '0;
         frame_q    <= '0;
         pending_q  <= 1'b0;
         bclk_q     <= 1'b0;
         lrck_q     <= 1'b0;
         data_q     <= 1'b0;
         underrun_q <= '0;
         overrun_q  <= '0;
      end else begin
         div_q      <= div_d;
         bit_q      <= bit_d;
         holding_q  <= holding_d;
         frame_q    <= frame_d;
         pending_q  <= pending_d;
         bclk_q     <= bclk_d;
         lrck_q     <= lrck_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign i2s_bclk       = bclk_q;
   assign i2s_lrck       = lrck_q;
   assign i2s_data       = data_q;
   assign underrun_count = underrun_q;
   assign overrun_count  = overrun_q;

endmodule
